// File: rtl/genius_tempo_sched.sv
// Playback tempo scheduler for the Genius game: walks the colour sequence through
// LED-on/LED-off phases locked to one of four divided game clocks.
module genius_tempo_sched #(
    parameter int LEN_W = 6
) (
    input  logic             clk_50MHz,
    input  logic             reset,
    input  logic             clk_025Hz,
    input  logic             clk_05Hz,
    input  logic             clk_1Hz,
    input  logic             clk_2Hz,
    input  logic [1:0]       speed_sel,
    input  logic             start,
    input  logic [LEN_W-1:0] seq_len,
    input  logic             abort,
    output logic [LEN_W-1:0] step_idx,
    output logic             show,
    output logic             step_strobe,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, ARM, ON, OFF, FIN} state_t;

    state_t           state, state_d;
    logic [1:0]       speed_q, speed_d;
    logic [LEN_W-1:0] len_q, len_d, idx_d;
    logic             sel, sel_start;
    logic             sel_q, sel_q_d;
    logic             rise_q, fall_q, rise_q_d, fall_q_d;
    logic             show_d, strobe_d, busy_d, done_d;

    function automatic logic pick_clk(input logic [1:0] s, input logic c0, input logic c1,
                                      input logic c2, input logic c3);
        logic r;
        case (s)
            2'd0:    r = c0;
            2'd1:    r = c1;
            2'd2:    r = c2;
            default: r = c3;
        endcase
        return r;
    endfunction

    assign sel       = pick_clk(speed_q,   clk_025Hz, clk_05Hz, clk_1Hz, clk_2Hz);
    assign sel_start = pick_clk(speed_sel, clk_025Hz, clk_05Hz, clk_1Hz, clk_2Hz);

    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            speed_q     <= 2'd0;
            len_q       <= '0;
            step_idx    <= '0;
            sel_q       <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            show        <= 1'b0;
            step_strobe <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_d;
            speed_q     <= speed_d;
            len_q       <= len_d;
            step_idx    <= idx_d;
            sel_q       <= sel_q_d;
            rise_q      <= rise_q_d;
            fall_q      <= fall_q_d;
            show        <= show_d;
            step_strobe <= strobe_d;
            busy        <= busy_d;
            done        <= done_d;
        end
    end

    // Edges are registered once before the FSM acts on them, so every phase change
    // lands two clk_50MHz edges after the tempo input moved.
    always_comb begin
        state_d  = state;
        speed_d  = speed_q;
        len_d    = len_q;
        idx_d    = step_idx;
        sel_q_d  = sel;
        rise_q_d = sel & ~sel_q;
        fall_q_d = ~sel & sel_q;
        show_d   = show;
        strobe_d = 1'b0;
        busy_d   = busy;
        done_d   = 1'b0;

        if (abort) begin
            state_d = IDLE;
            idx_d   = '0;
            show_d  = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (seq_len != '0) begin
                            state_d  = ARM;
                            speed_d  = speed_sel;
                            len_d    = seq_len;
                            idx_d    = '0;
                            busy_d   = 1'b1;
                            // Preload history with the new clock so the mux switch is not an edge.
                            sel_q_d  = sel_start;
                            rise_q_d = 1'b0;
                            fall_q_d = 1'b0;
                        end else begin
                            state_d = FIN;
                        end
                    end
                end
                ARM: begin
                    if (rise_q) begin
                        state_d  = ON;
                        show_d   = 1'b1;
                        strobe_d = 1'b1;
                    end
                end
                ON: begin
                    if (fall_q) begin
                        state_d = OFF;
                        show_d  = 1'b0;
                    end
                end
                OFF: begin
                    if (rise_q) begin
                        if (step_idx == len_q - LEN_W'(1)) begin
                            state_d = FIN;
                        end else begin
                            state_d  = ON;
                            idx_d    = step_idx + LEN_W'(1);
                            show_d   = 1'b1;
                            strobe_d = 1'b1;
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_genius_tempo_sched.sv
// Self-checking bench for genius_tempo_sched: free-running tempo clocks, an
// edge-counting playback model compared every cycle, plus directed literal checks.
module tb_genius_tempo_sched;

    localparam int LEN_W = 6;

    logic             clk_50MHz = 1'b0;
    logic             reset = 1'b0;
    logic [3:0]       tempo_lvl = 4'b0000;
    logic             clk_025Hz, clk_05Hz, clk_1Hz, clk_2Hz;
    logic [1:0]       speed_sel = 2'd0;
    logic             start = 1'b0;
    logic [LEN_W-1:0] seq_len = '0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] step_idx;
    logic             show, step_strobe, busy, done;

    int checks = 0;
    int errors = 0;
    int tempo_hp  [4] = '{80, 40, 20, 10};
    int tempo_cnt [4] = '{0, 0, 0, 0};

    int strobe_cnt = 0;
    int done_cnt = 0;
    int show_cnt = 0;
    int run_len = 0;
    int last_on = 0;
    int idx_log [$];

    assign clk_025Hz = tempo_lvl[0];
    assign clk_05Hz  = tempo_lvl[1];
    assign clk_1Hz   = tempo_lvl[2];
    assign clk_2Hz   = tempo_lvl[3];

    always #5 clk_50MHz = ~clk_50MHz;

    genius_tempo_sched #(.LEN_W(LEN_W)) dut (
        .clk_50MHz   (clk_50MHz),
        .reset       (reset),
        .clk_025Hz   (clk_025Hz),
        .clk_05Hz    (clk_05Hz),
        .clk_1Hz     (clk_1Hz),
        .clk_2Hz     (clk_2Hz),
        .speed_sel   (speed_sel),
        .start       (start),
        .seq_len     (seq_len),
        .abort       (abort),
        .step_idx    (step_idx),
        .show        (show),
        .step_strobe (step_strobe),
        .busy        (busy),
        .done        (done)
    );

    // Playback model: a sequence consumes tempo rises; rise n lights step n-1, rise len+1
    // finishes. Any edge takes effect one clock after it is first sampled.
    int         m_idx = 0, m_rises = 0, m_len = 0;
    bit         m_show = 0, m_strobe = 0, m_busy = 0, m_done = 0;
    bit         m_active = 0, m_fin = 0, m_prev = 0, m_pr = 0, m_pf = 0;
    logic [1:0] m_speed = 2'd0;

    always @(posedge clk_50MHz or negedge reset) begin
        bit lvl, act_rise, act_fall, new_pr, new_pf;
        if (!reset) begin
            m_idx = 0; m_rises = 0; m_len = 0; m_speed = 2'd0;
            m_show = 0; m_strobe = 0; m_busy = 0; m_done = 0;
            m_active = 0; m_fin = 0; m_prev = 0; m_pr = 0; m_pf = 0;
        end else begin
            lvl      = tempo_lvl[m_speed];
            act_rise = m_pr;
            act_fall = m_pf;
            new_pr   = lvl & !m_prev;
            new_pf   = !lvl & m_prev;
            m_prev   = lvl;
            m_strobe = 0;
            m_done   = 0;
            if (abort) begin
                m_active = 0; m_fin = 0; m_show = 0; m_busy = 0; m_idx = 0;
            end else if (m_fin) begin
                m_fin = 0; m_done = 1; m_busy = 0; m_idx = 0;
            end else if (!m_active) begin
                if (start) begin
                    if (seq_len == 0) begin
                        m_fin = 1;
                    end else begin
                        m_active = 1; m_busy = 1; m_idx = 0; m_rises = 0;
                        m_speed = speed_sel; m_len = int'(seq_len);
                        m_prev = tempo_lvl[speed_sel];
                        new_pr = 0; new_pf = 0;
                    end
                end
            end else if (act_rise) begin
                if (m_rises == m_len) begin
                    m_active = 0; m_fin = 1;
                end else begin
                    m_idx = m_rises; m_rises++; m_show = 1; m_strobe = 1;
                end
            end else if (act_fall && m_show) begin
                m_show = 0;
            end
            m_pr = new_pr;
            m_pf = new_pf;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clk_50MHz cycle: advance tempo clocks after the edge, compare on the falling edge.
    task automatic tick();
        @(posedge clk_50MHz);
        #1;
        for (int i = 0; i < 4; i++) begin
            tempo_cnt[i]++;
            if (tempo_cnt[i] == tempo_hp[i]) begin
                tempo_cnt[i] = 0;
                tempo_lvl[i] = ~tempo_lvl[i];
            end
        end
        @(negedge clk_50MHz);
        checkOutput("cyc_step_idx", int'(step_idx), m_idx);
        checkOutput("cyc_show", int'(show), int'(m_show));
        checkOutput("cyc_step_strobe", int'(step_strobe), int'(m_strobe));
        checkOutput("cyc_busy", int'(busy), int'(m_busy));
        checkOutput("cyc_done", int'(done), int'(m_done));
        if (step_strobe) begin
            strobe_cnt++;
            idx_log.push_back(int'(step_idx));
        end
        if (done) done_cnt++;
        if (show) begin
            show_cnt++;
            run_len++;
        end else if (run_len != 0) begin
            last_on = run_len;
            run_len = 0;
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [LEN_W-1:0] len,
                                 input logic [1:0] spd, input logic ab);
        start     = st;
        seq_len   = len;
        speed_sel = spd;
        abort     = ab;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic waitDone(input string name, input int budget);
        int base = done_cnt;
        int n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, int'(done_cnt != base), 1);
    endtask

    task automatic waitStrobes(input string name, input int target, input int budget);
        int n = 0;
        while (strobe_cnt < target && n < budget) begin
            tick();
            n++;
        end
        checkOutput(name, int'(strobe_cnt >= target), 1);
    endtask

    initial begin
        int sb, db, lb, sc, bad;

        // Reset held while inputs wiggle
        for (int i = 0; i < 10; i++) begin
            start     = i[0];
            abort     = i[1];
            speed_sel = i[1:0];
            seq_len   = LEN_W'(i + 1);
            tick();
            checkOutput("rst_outputs", int'({step_idx, show, step_strobe, busy, done}), 0);
        end
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b1;
        sb = strobe_cnt;
        runCycles(300);
        checkOutput("idle_outputs", int'({step_idx, show, step_strobe, busy, done}), 0);
        checkOutput("idle_no_strobe", strobe_cnt - sb, 0);

        // Basic play at 1 Hz, 3 steps
        sb = strobe_cnt; db = done_cnt; lb = idx_log.size();
        applyStimulus(1'b1, 6'd3, 2'd2, 1'b0);
        checkOutput("basic_busy_after_start", int'(busy), 1);
        waitDone("basic_done_seen", 1000);
        runCycles(5);
        checkOutput("basic_strobes", strobe_cnt - sb, 3);
        checkOutput("basic_idx0", idx_log[lb], 0);
        checkOutput("basic_idx1", idx_log[lb + 1], 1);
        checkOutput("basic_idx2", idx_log[lb + 2], 2);
        checkOutput("basic_on_time", last_on, 20);
        checkOutput("basic_done_count", done_cnt - db, 1);
        checkOutput("basic_busy_end", int'(busy), 0);

        // Rate select: 2 Hz then 0.25 Hz
        sb = strobe_cnt;
        applyStimulus(1'b1, 6'd2, 2'd3, 1'b0);
        waitDone("fast_done_seen", 500);
        checkOutput("fast_strobes", strobe_cnt - sb, 2);
        checkOutput("fast_on_time", last_on, 10);
        sb = strobe_cnt;
        applyStimulus(1'b1, 6'd2, 2'd0, 1'b0);
        waitDone("slow_done_seen", 1000);
        checkOutput("slow_strobes", strobe_cnt - sb, 2);
        checkOutput("slow_on_time", last_on, 80);

        // Zero length
        sb = strobe_cnt; sc = show_cnt;
        applyStimulus(1'b1, 6'd0, 2'd2, 1'b0);
        checkOutput("zero_done_c1", int'(done), 0);
        checkOutput("zero_busy_c1", int'(busy), 0);
        tick();
        checkOutput("zero_done_c2", int'(done), 1);
        tick();
        checkOutput("zero_done_c3", int'(done), 0);
        checkOutput("zero_no_strobe", strobe_cnt - sb, 0);
        checkOutput("zero_no_show", show_cnt - sc, 0);

        // Second start ignored, abort during step 2
        sb = strobe_cnt; db = done_cnt;
        applyStimulus(1'b1, 6'd5, 2'd2, 1'b0);
        waitStrobes("abort_step1_seen", sb + 2, 200);
        applyStimulus(1'b1, 6'd1, 2'd0, 1'b0);
        waitStrobes("abort_step2_seen", sb + 3, 200);
        runCycles(3);
        applyStimulus(1'b0, 6'd0, 2'd2, 1'b1);
        checkOutput("abort_show", int'(show), 0);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_idx", int'(step_idx), 0);
        runCycles(200);
        checkOutput("abort_no_done", done_cnt - db, 0);
        checkOutput("abort_strobes", strobe_cnt - sb, 3);

        // Abort and start together: abort wins
        sb = strobe_cnt;
        applyStimulus(1'b1, 6'd3, 2'd3, 1'b1);
        checkOutput("abort_start_busy", int'(busy), 0);
        runCycles(60);
        checkOutput("abort_start_no_strobe", strobe_cnt - sb, 0);

        // Asynchronous reset mid-sequence
        sb = strobe_cnt; db = done_cnt;
        applyStimulus(1'b1, 6'd3, 2'd3, 1'b0);
        waitStrobes("rst_mid_step_seen", sb + 1, 100);
        reset = 1'b0;
        #1;
        checkOutput("rst_mid_async", int'({step_idx, show, step_strobe, busy, done}), 0);
        tick();
        reset = 1'b1;
        runCycles(100);
        checkOutput("rst_mid_no_done", done_cnt - db, 0);
        checkOutput("rst_mid_idle", int'(busy), 0);

        // Maximum length starting while clk_05Hz is already high
        bad = 0;
        while (!(tempo_lvl[1] == 1'b1 && tempo_cnt[1] == 0) && bad < 200) begin
            tick();
            bad++;
        end
        checkOutput("max_phase_found", int'(bad < 200), 1);
        sb = strobe_cnt; db = done_cnt; lb = idx_log.size();
        applyStimulus(1'b1, 6'd63, 2'd1, 1'b0);
        runCycles(60);
        checkOutput("max_no_false_edge", strobe_cnt - sb, 0);
        waitDone("max_done_seen", 6000);
        runCycles(3);
        checkOutput("max_strobes", strobe_cnt - sb, 63);
        checkOutput("max_last_idx", idx_log[idx_log.size() - 1], 62);
        bad = 0;
        for (int i = 0; i < 63; i++) begin
            if (lb + i >= idx_log.size() || idx_log[lb + i] != i) bad++;
        end
        checkOutput("max_idx_sequence", bad, 0);
        checkOutput("max_done_count", done_cnt - db, 1);
        checkOutput("max_idx_end", int'(step_idx), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
